uart_frame_tx: RTL and testbench

Frame transmitter for the UART command protocol. Frame format is preamble 0x55, command, length, then payload bytes.
- Accepts a DMA-style payload stream (tdata/tlast/tvalid/tready) plus a command byte.
- Buffers the payload to learn its length.
- Serialises the complete frame byte-by-byte into the Uart_Drive user TX interface.
- Sits between a DMA/user source and Uart_Drive. It is the sending end of the frame that the Uart_DMA receive path parses.

---
 rtl/uart_frame_pkg.sv | 33 +++
 rtl/frame_byte_fifo.sv | 46 ++++
 rtl/uart_frame_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_frame_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared frame constants and state encodings for the UART command-frame
// transmitter. The receive path imports the same package so both ends agree
// on the preamble value and on the field order.
package uart_frame_pkg;

    // Frame start byte
    localparam logic [7:0] FRAME_PREAMBLE = 8'h55;

    // Field order on the wire: preamble, command, length, payload
    typedef enum logic [1:0] {
        FIELD_PRE  = 2'd0,
        FIELD_CMD  = 2'd1,
        FIELD_LEN  = 2'd2,
        FIELD_DATA = 2'd3
    } frame_field_t;

    // Transmitter control states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_SEND_PRE  = 3'd2,
        ST_SEND_CMD  = 3'd3,
        ST_SEND_LEN  = 3'd4,
        ST_SEND_DATA = 3'd5
    } frame_state_t;

    // True for the states that put a byte on the UART side
    function automatic logic is_send_state(input frame_state_t s);
        return (s == ST_SEND_PRE) || (s == ST_SEND_CMD) ||
               (s == ST_SEND_LEN) || (s == ST_SEND_DATA);
    endfunction

endpackage

// File: rtl/frame_byte_fifo.sv
// Single-clock byte FIFO used to hold one frame's payload while its length is
// being counted. Storage is a plain array so it maps onto block RAM; the read
// port is registered, so data appears the cycle after rd_en.
module frame_byte_fifo #(
    parameter int P_AW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data
);

    logic [7:0]      mem [0:(1 << P_AW) - 1];
    logic [P_AW-1:0] wr_ptr_reg;
    logic [P_AW-1:0] rd_ptr_reg;
    logic [7:0]      rd_data_reg;

    // Write port: no reset on the storage itself
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers and registered read data; reset discards any buffered payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            rd_data_reg <= 8'h00;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/uart_frame_tx.sv
// Command-frame transmitter: collects a payload stream, counts it, then sends
// preamble, command, length and payload one byte at a time to the UART driver.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] P_PREAMBLE = FRAME_PREAMBLE,
    parameter int         P_MAX_LEN  = 255,
    parameter int         P_FIFO_AW  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_cmd,
    input  logic [7:0] i_dma_tdata,
    input  logic       i_dma_tlast,
    input  logic       i_dma_tvalid,
    output logic       o_dma_tready,
    output logic [7:0] o_usr_tx_data,
    output logic       o_usr_tx_valid,
    input  logic       i_usr_tx_ready,
    output logic       o_busy,
    output logic       o_len_err
);

    localparam logic [7:0] MAX_LEN8 = 8'(P_MAX_LEN);

    frame_state_t state_reg;
    logic [7:0]   cmd_reg;
    logic [7:0]   count_reg;
    logic [7:0]   data_idx_reg;
    logic         wait_busy_reg;
    logic         tready_reg;
    logic [7:0]   tx_data_reg;
    logic         tx_valid_reg;
    logic         busy_reg;
    logic         len_err_reg;

    logic         beat_acc;
    logic [7:0]   count_inc;
    logic         can_issue;
    logic         last_data;
    logic         fifo_rd_en;
    logic [7:0]   fifo_rd_data;

    assign beat_acc  = i_dma_tvalid & tready_reg;
    assign count_inc = count_reg + 8'd1;
    // A byte may go out only once the driver has dropped ready after the
    // previous strobe and then raised it again.
    assign can_issue = is_send_state(state_reg) & ~wait_busy_reg & i_usr_tx_ready;
    assign last_data = (data_idx_reg == (count_reg - 8'd1));
    // Read ahead: fetch payload byte 0 on the length strobe, and the next one
    // on every data strobe, so the registered FIFO output is ready in time.
    assign fifo_rd_en = can_issue &
                        ((state_reg == ST_SEND_LEN) ||
                         ((state_reg == ST_SEND_DATA) && !last_data));

    frame_byte_fifo #(
        .P_AW (P_FIFO_AW)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (beat_acc),
        .wr_data (i_dma_tdata),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data)
    );

    // Frame control FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= 8'h00;
            count_reg     <= 8'h00;
            data_idx_reg  <= 8'h00;
            wait_busy_reg <= 1'b0;
            tready_reg    <= 1'b0;
            tx_data_reg   <= 8'h00;
            tx_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            len_err_reg   <= 1'b0;
        end else begin
            tx_valid_reg <= 1'b0;
            len_err_reg  <= 1'b0;

            // Re-arm the issue path once the driver has shown it is busy
            if (wait_busy_reg && !i_usr_tx_ready) begin
                wait_busy_reg <= 1'b0;
            end

            if (can_issue) begin
                tx_valid_reg  <= 1'b1;
                wait_busy_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    tready_reg <= 1'b1;
                    if (beat_acc) begin
                        cmd_reg   <= i_cmd;
                        count_reg <= 8'd1;
                        busy_reg  <= 1'b1;
                        if (i_dma_tlast || (MAX_LEN8 == 8'd1)) begin
                            state_reg   <= ST_SEND_PRE;
                            tready_reg  <= 1'b0;
                            len_err_reg <= ~i_dma_tlast;
                        end else begin
                            state_reg <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (beat_acc) begin
                        count_reg <= count_inc;
                        if (i_dma_tlast || (count_inc == MAX_LEN8)) begin
                            state_reg   <= ST_SEND_PRE;
                            tready_reg  <= 1'b0;
                            len_err_reg <= ~i_dma_tlast;
                        end
                    end
                end
                ST_SEND_PRE: begin
                    if (can_issue) begin
                        tx_data_reg <= P_PREAMBLE;
                        state_reg   <= ST_SEND_CMD;
                    end
                end
                ST_SEND_CMD: begin
                    if (can_issue) begin
                        tx_data_reg <= cmd_reg;
                        state_reg   <= ST_SEND_LEN;
                    end
                end
                ST_SEND_LEN: begin
                    if (can_issue) begin
                        tx_data_reg  <= count_reg;
                        data_idx_reg <= 8'd0;
                        state_reg    <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (can_issue) begin
                        tx_data_reg  <= fifo_rd_data;
                        data_idx_reg <= data_idx_reg + 8'd1;
                        if (last_data) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            count_reg <= 8'd0;
                        end
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    tready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_dma_tready   = tready_reg;
    assign o_usr_tx_data  = tx_data_reg;
    assign o_usr_tx_valid = tx_valid_reg;
    assign o_busy         = busy_reg;
    assign o_len_err      = len_err_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: a scoreboard queue of expected UART bytes
// is filled as each frame is driven, and a monitor pops and compares on every
// strobe. A small process imitates the UART driver's ready behaviour.
module tb_uart_frame_tx;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_cmd;
    logic [7:0] i_dma_tdata;
    logic       i_dma_tlast;
    logic       i_dma_tvalid;
    logic       o_dma_tready;
    logic [7:0] o_usr_tx_data;
    logic       o_usr_tx_valid;
    logic       i_usr_tx_ready;
    logic       o_busy;
    logic       o_len_err;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         strobe_total = 0;
    int         len_err_cnt  = 0;
    logic [7:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    uart_frame_tx dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cmd          (i_cmd),
        .i_dma_tdata    (i_dma_tdata),
        .i_dma_tlast    (i_dma_tlast),
        .i_dma_tvalid   (i_dma_tvalid),
        .o_dma_tready   (o_dma_tready),
        .o_usr_tx_data  (o_usr_tx_data),
        .o_usr_tx_valid (o_usr_tx_valid),
        .i_usr_tx_ready (i_usr_tx_ready),
        .o_busy         (o_busy),
        .o_len_err      (o_len_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] cmd, input logic [7:0] payload[$]);
        exp_q.push_back(8'h55);
        exp_q.push_back(cmd);
        exp_q.push_back(8'(payload.size()));
        foreach (payload[k]) exp_q.push_back(payload[k]);
        $display("[TB] queued frame cmd=%02h len=%0d", cmd, payload.size());
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic drive_beat(input logic [7:0] cmd, input logic [7:0] d,
                              input logic last, output bit ok);
        i_cmd        = cmd;
        i_dma_tdata  = d;
        i_dma_tlast  = last;
        i_dma_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (o_dma_tready) begin
                ok = 1'b1;
                @(negedge i_clk);
                break;
            end
            @(negedge i_clk);
        end
        i_dma_tvalid = 1'b0;
        i_dma_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        bit timed_out = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if (exp_q.size() == 0 && !o_busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge i_clk);
        end
        check("done_timeout", 32'(timed_out), 0);
        repeat (12) @(negedge i_clk);
    endtask

    // UART driver model: ready stays high 3 cycles after a strobe, then low
    initial begin
        i_usr_tx_ready = 1'b1;
        forever begin
            @(negedge i_clk);
            if (o_usr_tx_valid) begin
                repeat (3) @(negedge i_clk);
                i_usr_tx_ready = 1'b0;
                repeat (4) @(negedge i_clk);
                i_usr_tx_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard compare, duplicate-strobe and len_err tracking
    initial begin
        logic       prev_valid = 1'b0;
        logic [7:0] exp_b;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                if (o_len_err) len_err_cnt++;
                if (o_usr_tx_valid) begin
                    strobe_total++;
                    if (prev_valid) check("dup_strobe", 1, 0);
                    if (exp_q.size() == 0) begin
                        check("extra_strobe", 32'(o_usr_tx_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("tx_byte", 32'(o_usr_tx_data), 32'(exp_b));
                        $display("[TB] strobe %0d byte %02h exp %02h", strobe_total, o_usr_tx_data, exp_b);
                    end
                    check("tready_in_send", 32'(o_dma_tready), 0);
                end
                prev_valid = o_usr_tx_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        bit         ok;
        int         base;
        int         target;
        logic [7:0] pl[$];

        i_rst = 1'b1; i_cmd = 8'h00; i_dma_tdata = 8'h00;
        i_dma_tlast = 1'b0; i_dma_tvalid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_tready", 32'(o_dma_tready), 0);
        check("rst_valid", 32'(o_usr_tx_valid), 0);
        check("rst_data", 32'(o_usr_tx_data), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_len_err", 32'(o_len_err), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("tready_after_rst", 32'(o_dma_tready), 1);

        // One-byte frame, with latency check
        base = strobe_total;
        pl = '{8'h77};
        push_frame(8'h01, pl);
        drive_beat(8'h01, 8'h77, 1'b1, ok);
        check("t1_accept", 32'(ok), 1);
        check("t1_busy", 32'(o_busy), 1);
        check("t1_valid_early", 32'(o_usr_tx_valid), 0);
        @(negedge i_clk);
        check("t1_latency_valid", 32'(o_usr_tx_valid), 1);
        wait_done();
        check("t1_busy_low", 32'(o_busy), 0);
        check("t1_strobes", 32'(strobe_total - base), 4);

        // Four-byte frame followed by a beat held during sending
        base = strobe_total;
        pl = '{8'h10, 8'h11, 8'h12, 8'h13};
        push_frame(8'h02, pl);
        pl = '{8'hC3};
        push_frame(8'h03, pl);
        for (int i = 0; i < 4; i++) begin
            drive_beat(8'h02, 8'(8'h10 + i), (i == 3), ok);
            check("t2_accept", 32'(ok), 1);
        end
        drive_beat(8'h03, 8'hC3, 1'b1, ok);
        check("t5_accept", 32'(ok), 1);
        wait_done();
        check("t2_strobes", 32'(strobe_total - base), 11);

        // 256 beats without a closing tlast until the last one
        base = strobe_total;
        pl = {};
        for (int i = 0; i < 255; i++) pl.push_back(8'(i));
        push_frame(8'h05, pl);
        pl = '{8'hFF};
        push_frame(8'h05, pl);
        check("t4_len_err_before", 32'(len_err_cnt), 0);
        for (int i = 0; i < 256; i++) begin
            drive_beat(8'h05, 8'(i), (i == 255), ok);
            if (!ok) check("t4_accept", 32'(ok), 1);
        end
        wait_done();
        check("t4_len_err_once", 32'(len_err_cnt), 1);
        check("t4_strobes", 32'(strobe_total - base), 262);

        // Reset after the length byte, then a clean one-byte frame
        pl = '{8'hA0, 8'hA1};
        push_frame(8'h07, pl);
        target = strobe_total + 3;
        drive_beat(8'h07, 8'hA0, 1'b0, ok);
        drive_beat(8'h07, 8'hA1, 1'b1, ok);
        for (int c = 0; c < 500 && strobe_total < target; c++) @(negedge i_clk);
        check("t6_reached_len", 32'(strobe_total >= target), 1);
        @(negedge i_clk);
        i_rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_rst_valid", 32'(o_usr_tx_valid), 0);
        check("t6_rst_data", 32'(o_usr_tx_data), 0);
        check("t6_rst_busy", 32'(o_busy), 0);
        check("t6_rst_tready", 32'(o_dma_tready), 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        base = strobe_total;
        repeat (10) @(negedge i_clk);
        check("t6_no_resume", 32'(strobe_total - base), 0);
        pl = '{8'h5A};
        push_frame(8'h09, pl);
        drive_beat(8'h09, 8'h5A, 1'b1, ok);
        check("t6_accept", 32'(ok), 1);
        wait_done();
        check("t6_strobes", 32'(strobe_total - base), 4);
        check("final_len_err", 32'(len_err_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
